// File: rtl/pacman_pkg.sv
// pacman_pkg: shared game states, screen geometry and colour constants for the pacman pipeline.
package pacman_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, WIN, OVER} state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int DEF_CELL = 40;
  localparam int DEF_COLS = SCREEN_W / DEF_CELL;
  localparam int DEF_ROWS = SCREEN_H / DEF_CELL;
  localparam logic [7:0] COL_BG     = 8'h00;
  localparam logic [7:0] COL_PELLET = 8'hFC;
  localparam logic [7:0] COL_POWER  = 8'hFF;
endpackage

// File: rtl/pellet_tracker_cell_index.sv
// cell_index: divides a 10-bit pixel coordinate by CELL with a comparator chain; ok flags idx < N.
module cell_index #(
  parameter int CELL = 40,
  parameter int N    = 16
) (
  input  logic [9:0] p,
  output logic [3:0] idx,
  output logic       ok
);
  always_comb begin
    idx = '0;
    for (int k = 1; k < N; k++) idx = idx + 4'(int'(p) >= k * CELL);
  end
  assign ok = int'(p) < N * CELL;
endmodule

// File: rtl/pellet_tracker.sv
// pellet_tracker: clears pellets under pacman on move ticks, keeps score/win and drives pellet_fill.
// Optional power pellets in the four corner cells are enabled by defining PELLET_POWER_EN.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int CELL       = DEF_CELL,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int PELLET_PTS = 10,
  parameter int DOT        = 4,
  parameter logic [COLS*ROWS-1:0] INIT_MAP = '1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        lose,
  input  logic        move_tick,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [15:0] score,
  output logic        win,
  output logic        eat_pulse,
  output logic [7:0]  pellets_left,
  output logic        pellet_fill,
  output logic        power_active
);
  function automatic logic [7:0] popcount(input logic [COLS*ROWS-1:0] m);
    popcount = '0;
    for (int i = 0; i < COLS * ROWS; i++) popcount = popcount + 8'(m[i]);
  endfunction
  localparam logic [7:0] INIT_LEFT = popcount(INIT_MAP);

  state_t                 state_q;
  logic [COLS*ROWS-1:0]   bitmap_q;
  logic [15:0]            score_q, pts;
  logic [7:0]             left_q, s2_idx, r_idx;
  logic                   win_q, eat_q, v1_q, eat;
  logic [3:0]             col1_q, row1_q, xcol, yrow, hcol, vrow;
  logic                   xok, yok, hok, vok;
  logic [16:0]            sum;
  logic [10:0]            hc, vc;

  cell_index #(.CELL(CELL), .N(COLS)) u_px (.p(pac_x),  .idx(xcol), .ok(xok));
  cell_index #(.CELL(CELL), .N(ROWS)) u_py (.p(pac_y),  .idx(yrow), .ok(yok));
  cell_index #(.CELL(CELL), .N(COLS)) u_hx (.p(hCount), .idx(hcol), .ok(hok));
  cell_index #(.CELL(CELL), .N(ROWS)) u_vy (.p(vCount), .idx(vrow), .ok(vok));

  assign s2_idx = 8'(int'(row1_q) * COLS + int'(col1_q));
  assign eat    = v1_q && bitmap_q[s2_idx];
`ifdef PELLET_POWER_EN
  logic       corner, power_q;
  logic [8:0] pow_cnt_q;
  assign corner = s2_idx == 8'd0 || s2_idx == 8'(COLS - 1) ||
                  s2_idx == 8'((ROWS - 1) * COLS) || s2_idx == 8'(COLS * ROWS - 1);
  assign pts    = corner ? 16'd50 : 16'(PELLET_PTS);
`else
  assign pts    = 16'(PELLET_PTS);
`endif
  assign sum = {1'b0, score_q} + {1'b0, pts};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      bitmap_q <= INIT_MAP;
      score_q  <= '0;
      left_q   <= INIT_LEFT;
      win_q    <= 1'b0;
      eat_q    <= 1'b0;
      v1_q     <= 1'b0;
      col1_q   <= '0;
      row1_q   <= '0;
    end else begin
      eat_q  <= eat;
      // a tick only survives into S2 if the game stays in PLAY at this edge
      v1_q   <= state_q == PLAY && !lose && left_q != 8'd0 && move_tick && xok && yok;
      col1_q <= xcol;
      row1_q <= yrow;
      if (eat) begin
        bitmap_q[s2_idx] <= 1'b0;
        score_q          <= sum[16] ? 16'hFFFF : sum[15:0];
        left_q           <= left_q - 8'd1;
      end
      case (state_q)
        IDLE: begin
          bitmap_q <= INIT_MAP;
          score_q  <= '0;
          left_q   <= INIT_LEFT;
          if (start) state_q <= PLAY;
        end
        PLAY:
          if (lose) state_q <= OVER;
          else if (left_q == 8'd0) begin
            state_q <= WIN;
            win_q   <= 1'b1;
          end
        default:
          if (ack) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
          end
      endcase
    end

`ifdef PELLET_POWER_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pow_cnt_q <= '0;
      power_q   <= 1'b0;
    end else if (state_q != PLAY || lose || left_q == 8'd0) begin
      pow_cnt_q <= '0;
      power_q   <= 1'b0;
    end else if (eat && corner) begin
      pow_cnt_q <= 9'd300;
      power_q   <= 1'b1;
    end else if (move_tick && pow_cnt_q != 9'd0) begin
      pow_cnt_q <= pow_cnt_q - 9'd1;
      power_q   <= pow_cnt_q != 9'd1;
    end
  assign power_active = power_q;
`else
  assign power_active = 1'b0;
`endif

  assign r_idx = 8'(int'(vrow) * COLS + int'(hcol));
  assign hc    = 11'(int'(hcol) * CELL + CELL / 2);
  assign vc    = 11'(int'(vrow) * CELL + CELL / 2);
  // |a - c| < DOT/2 written as two unsigned compares to avoid signed arithmetic
  assign pellet_fill = bright && hok && vok && bitmap_q[r_idx] &&
                       ({1'b0, hCount} + 11'(DOT / 2) > hc) && ({1'b0, hCount} < hc + 11'(DOT / 2)) &&
                       ({1'b0, vCount} + 11'(DOT / 2) > vc) && ({1'b0, vCount} < vc + 11'(DOT / 2));

  assign score        = score_q;
  assign win          = win_q;
  assign eat_pulse    = eat_q;
  assign pellets_left = left_q;
endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker: directed checks of pellet eating, scoring, win/lose, reset and rendering.
module tb_pellet_tracker;
  logic        clk = 0, reset = 1, start = 0, ack = 0, lose = 0, move_tick = 0, bright = 0;
  logic [9:0]  pac_x = 0, pac_y = 0, hCount = 0, vCount = 0;
  logic [15:0] score, b_score;
  logic        win, eat_pulse, pellet_fill, power_active;
  logic        b_win, b_eat, b_fill, b_power;
  logic [7:0]  left, b_left;
  int          total = 0, bad = 0;
`ifdef PELLET_POWER_EN
  localparam int CPTS = 50;
`else
  localparam int CPTS = 10;
`endif

  always #5 clk = ~clk;

  pellet_tracker dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .lose(lose), .move_tick(move_tick),
    .pac_x(pac_x), .pac_y(pac_y), .bright(bright), .hCount(hCount), .vCount(vCount),
    .score(score), .win(win), .eat_pulse(eat_pulse), .pellets_left(left),
    .pellet_fill(pellet_fill), .power_active(power_active));

  pellet_tracker #(.INIT_MAP(192'h20)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .lose(lose), .move_tick(move_tick),
    .pac_x(pac_x), .pac_y(pac_y), .bright(bright), .hCount(hCount), .vCount(vCount),
    .score(b_score), .win(b_win), .eat_pulse(b_eat), .pellets_left(b_left),
    .pellet_fill(b_fill), .power_active(b_power));

  task automatic do_reset();
    @(negedge clk);
    reset = 0; start = 0; ack = 0; lose = 0; move_tick = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic go();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    move_tick = 1; pac_x = x; pac_y = y;
    @(negedge clk);
    move_tick = 0;
  endtask

  task automatic test_reset();
    #2 reset = 0;
    #1;
    total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
    total++; if (left !== 8'd192) begin bad++; $display("FAIL reset_left got=%0d exp=192", left); end
    total++; if (b_left !== 8'd1) begin bad++; $display("FAIL reset_left_one got=%0d exp=1", b_left); end
    total++; if ({win, eat_pulse, power_active} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {win, eat_pulse, power_active}); end
    @(negedge clk) reset = 1;
  endtask

  task automatic test_single();
    do_reset(); go();
    tick(10'd20, 10'd20);
    total++; if (eat_pulse !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", eat_pulse); end
    @(negedge clk);
    total++; if (eat_pulse !== 1'b1) begin bad++; $display("FAIL single_eat got=%b exp=1", eat_pulse); end
    total++; if (score !== 16'(CPTS)) begin bad++; $display("FAIL single_score got=%0d exp=%0d", score, CPTS); end
    total++; if (left !== 8'd191) begin bad++; $display("FAIL single_left got=%0d exp=191", left); end
    @(negedge clk);
    total++; if (eat_pulse !== 1'b0) begin bad++; $display("FAIL single_pulse_len got=%b exp=0", eat_pulse); end
`ifndef PELLET_POWER_EN
    total++; if (power_active !== 1'b0) begin bad++; $display("FAIL single_power got=%b exp=0", power_active); end
`endif
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset(); go();
    @(negedge clk); move_tick = 1; pac_x = 25; pac_y = 25;
    @(negedge clk); pac_x = 30; pac_y = 30;
    @(negedge clk); move_tick = 0;
    for (int i = 0; i < 4; i++) begin n += int'(eat_pulse); @(negedge clk); end
    total++; if (n !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", n); end
    total++; if (score !== 16'(CPTS)) begin bad++; $display("FAIL b2b_score got=%0d exp=%0d", score, CPTS); end
    total++; if (left !== 8'd191) begin bad++; $display("FAIL b2b_left got=%0d exp=191", left); end
  endtask

  task automatic test_win();
    do_reset(); go();
    tick(10'd220, 10'd20);
    @(negedge clk);
    total++; if (b_eat !== 1'b1) begin bad++; $display("FAIL win_eat got=%b exp=1", b_eat); end
    total++; if (b_left !== 8'd0) begin bad++; $display("FAIL win_left got=%0d exp=0", b_left); end
    total++; if (b_score !== 16'd10) begin bad++; $display("FAIL win_score got=%0d exp=10", b_score); end
    total++; if (b_win !== 1'b0) begin bad++; $display("FAIL win_early got=%b exp=0", b_win); end
    @(negedge clk);
    total++; if (b_win !== 1'b1) begin bad++; $display("FAIL win_rise got=%b exp=1", b_win); end
    @(negedge clk) ack = 1;
    @(negedge clk) ack = 0;
    total++; if (b_win !== 1'b0) begin bad++; $display("FAIL win_ack got=%b exp=0", b_win); end
    @(negedge clk);
    total++; if (b_left !== 8'd1) begin bad++; $display("FAIL win_reload got=%0d exp=1", b_left); end
  endtask

  task automatic test_lose();
    do_reset(); go();
    tick(10'd220, 10'd20);
    lose = 1;
    @(negedge clk) lose = 0;
    total++; if (b_score !== 16'd10) begin bad++; $display("FAIL lose_score got=%0d exp=10", b_score); end
    total++; if (b_left !== 8'd0) begin bad++; $display("FAIL lose_left got=%0d exp=0", b_left); end
    repeat (2) @(negedge clk);
    total++; if (b_win !== 1'b0) begin bad++; $display("FAIL lose_win got=%b exp=0", b_win); end
    go();
    total++; if (b_score !== 16'd10) begin bad++; $display("FAIL lose_frozen got=%0d exp=10", b_score); end
  endtask

  task automatic test_oob_reset();
    int n = 0;
    do_reset(); go();
    tick(10'd700, 10'd20);
    for (int i = 0; i < 4; i++) begin n += int'(eat_pulse); @(negedge clk); end
    total++; if (n !== 0 || score !== 16'd0) begin bad++; $display("FAIL oob got=%0d/%0d exp=0/0", n, score); end
    tick(10'd20, 10'd20);
    @(negedge clk);
    bright = 1; hCount = 20; vCount = 20; #1;
    total++; if (pellet_fill !== 1'b0) begin bad++; $display("FAIL eaten_fill got=%b exp=0", pellet_fill); end
    tick(10'd60, 10'd20);
    reset = 0; #1;
    total++; if (score !== 16'd0 || left !== 8'd192 || eat_pulse !== 1'b0) begin
      bad++; $display("FAIL midreset got=%0d/%0d/%b exp=0/192/0", score, left, eat_pulse); end
    @(negedge clk);
    total++; if (eat_pulse !== 1'b0 || pellet_fill !== 1'b1) begin
      bad++; $display("FAIL midreset_restore got=%b/%b exp=0/1", eat_pulse, pellet_fill); end
    reset = 1; bright = 0;
  endtask

  task automatic test_render();
    do_reset();
    bright = 1; hCount = 60; vCount = 60; #1;
    total++; if (pellet_fill !== 1'b1) begin bad++; $display("FAIL fill_centre got=%b exp=1", pellet_fill); end
    hCount = 63; #1;
    total++; if (pellet_fill !== 1'b0) begin bad++; $display("FAIL fill_63 got=%b exp=0", pellet_fill); end
    hCount = 61; #1;
    total++; if (pellet_fill !== 1'b1) begin bad++; $display("FAIL fill_61 got=%b exp=1", pellet_fill); end
    hCount = 58; #1;
    total++; if (pellet_fill !== 1'b0) begin bad++; $display("FAIL fill_58 got=%b exp=0", pellet_fill); end
    hCount = 60; bright = 0; #1;
    total++; if (pellet_fill !== 1'b0) begin bad++; $display("FAIL fill_dark got=%b exp=0", pellet_fill); end
    bright = 1; hCount = 220; vCount = 20; #1;
    total++; if (b_fill !== 1'b1 || pellet_fill !== 1'b1) begin bad++; $display("FAIL fill_cell5 got=%b/%b exp=1/1", b_fill, pellet_fill); end
    vCount = 480; #1;
    total++; if (pellet_fill !== 1'b0) begin bad++; $display("FAIL fill_vbound got=%b exp=0", pellet_fill); end
    bright = 0; vCount = 0;
  endtask

`ifdef PELLET_POWER_EN
  task automatic test_power();
    do_reset(); go();
    tick(10'd20, 10'd20);
    @(negedge clk);
    total++; if (power_active !== 1'b1) begin bad++; $display("FAIL power_on got=%b exp=1", power_active); end
    move_tick = 1; pac_x = 700; pac_y = 20;
    repeat (299) @(negedge clk);
    total++; if (power_active !== 1'b1) begin bad++; $display("FAIL power_299 got=%b exp=1", power_active); end
    @(negedge clk) move_tick = 0;
    total++; if (power_active !== 1'b0) begin bad++; $display("FAIL power_300 got=%b exp=0", power_active); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_win();
    test_lose();
    test_oob_reset();
    test_render();
`ifdef PELLET_POWER_EN
    test_power();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pellet_tracker.md
Name: pellet_tracker

Overview:
- Downstream consumer of the pacman movement stage: samples pacman's centre coordinates on each movement tick and clears the pellet in the maze cell pacman occupies.
- Accumulates `score` and raises `win` when the last pellet is eaten; `score` and `win` feed back into the movement stage.
- Also drives a combinational `pellet_fill` for the VGA colour mux.

Parameters:
- CELL, 40, cell edge in pixels (640x480 screen becomes a 16x12 grid)
- COLS, 16, grid columns
- ROWS, 12, grid rows
- PELLET_PTS, 10, points per normal pellet
- DOT, 4, pellet square edge in pixels, centred in the cell
- INIT_MAP, {192{1'b1}}, initial pellet bitmap; bit index = row*COLS+col

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; begins a game from IDLE
- ack  in  1  level; leaves WIN/OVER back to IDLE
- lose  in  1  level; game lost (from ghost logic)
- move_tick  in  1  one-cycle pulse; pac_x/pac_y are valid this cycle
- pac_x  in  10  pacman centre X, pixels
- pac_y  in  10  pacman centre Y, pixels
- bright  in  1  display-active qualifier
- hCount  in  10  current pixel X
- vCount  in  10  current pixel Y
- score  out  16  accumulated score, saturating
- win  out  1  high from the cycle after the last pellet is cleared until ack
- eat_pulse  out  1  one-cycle pulse per pellet eaten
- pellets_left  out  8  remaining pellet count
- pellet_fill  out  1  current pixel lies on a live pellet
- power_active  out  1  power mode (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; bitmap=INIT_MAP; score=0; win=0; eat_pulse=0; pellets_left=popcount(INIT_MAP); pipeline valids=0; power_active=0.
- States:
  - IDLE: bitmap and counters hold their reload values. When start==1, reload bitmap/score/pellets_left and go to PLAY.
  - PLAY: process movement ticks. lose==1 goes to OVER. pellets_left reaching 0 goes to WIN.
  - WIN: win=1. When ack==1, go to IDLE.
  - OVER: win=0; counters frozen. When ack==1, go to IDLE.
- Ignored inputs: start is ignored outside IDLE; ack is ignored in IDLE and PLAY; move_tick is ignored outside PLAY.
- Pipeline, 2 stages, one move_tick accepted per cycle:
  - S1 (cycle after the tick): register col=pac_x/CELL and row=pac_y/CELL, plus v1=move_tick&&in-bounds. In-bounds means pac_x<640 && pac_y<480; out-of-bounds ticks are dropped.
  - S2 (cycle after S1): if v1 and the bitmap bit is set, clear the bit, add PELLET_PTS to score saturating at 16'hFFFF, decrement pellets_left, and pulse eat_pulse.
  - eat_pulse therefore appears 2 cycles after move_tick.
  - Hazard: S2 reads the bitmap as committed at the previous edge. Back-to-back ticks into the same cell score exactly once; no bypass is needed.
- win rises the cycle after pellets_left becomes 0 (state WIN), i.e. 3 cycles after the final move_tick.
- Lose priority: lose in the same cycle as S2 eating the last pellet still counts the pellet, but the state goes to OVER, not WIN. Lose has priority.
- Pipeline flush: any exit from PLAY clears v1; in-flight ticks are discarded.
- Division by CELL is a constant divide implemented by a comparator chain. No `/` on a non-constant operand.
- pellet_fill (combinational) = bright && cell bit set && |hCount - (col*CELL+CELL/2)| < DOT/2 && the same test on vCount, where col/row come from hCount/vCount. Forced to 0 for vCount>=480 or hCount>=640.

Optional Feature:
- Macro: PELLET_POWER_EN.
- With macro defined:
  - The four corner cells (0,0), (15,0), (0,11), (15,11) are power pellets worth 50 points.
  - Eating one sets power_active=1 and loads a 9-bit counter with 300; the counter decrements on each move_tick in PLAY.
  - power_active drops when the counter reaches 0. A re-eat reloads the counter to 300.
  - power_active is cleared on leaving PLAY.
- Without macro: corners are normal pellets; power_active is tied 0.

Decomposition:
- Package pacman_pkg: state enum (IDLE, PLAY, WIN, OVER), screen constants (640, 480), COLS/ROWS/CELL defaults, colour constants.
- One sub-module, cell_index: constant divide of a 10-bit pixel coordinate by CELL, returning a 4-bit index and an in-range flag. Instantiated for the S1 pac coordinates and for the hCount/vCount render path.

Test Plan:
- Reset, start, one move_tick at (20,20) -> eat_pulse 2 cycles later; score=10; pellets_left=191.
- Two consecutive move_ticks at (25,25) then (30,30) (same cell 0,0) -> exactly one eat_pulse; score=10.
- INIT_MAP with only bit 5 set; start; tick at (220,20) -> score=10; pellets_left=0; win=1 three cycles after the tick; ack -> IDLE with win=0.
- Same setup, lose asserted in the S2 cycle -> score=10; state OVER; win stays 0.
- Tick at (700,20) -> no eat_pulse, score unchanged; reset low mid-pipeline -> all outputs back to reset values, bitmap restored.
- Render: bitmap bit at (1,1) set, bright=1, hCount=60, vCount=60 -> pellet_fill=1; hCount=63 -> 0. With PELLET_POWER_EN, tick at (20,20) -> score=50, power_active=1 for 300 ticks.
